// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flop,
// WIDTH bits processed LSB-first over WIDTH cycles, start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;
  logic             w_busy;
  logic             w_done;
  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Full-adder slice on the current LSBs and the running carry
  always_comb begin
    w_s        = r_opa[0] ^ r_opb[0] ^ r_c;
    w_cout     = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_c) | (r_opb[0] & r_c);
    w_last     = (r_cnt == LAST);
    w_acc_next = {w_s, r_acc[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa <= a;
            r_opb <= sub ? ~b : b;
            r_c   <= sub;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_opa <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb <= {1'b0, r_opb[WIDTH-1:1]};
          r_acc <= w_acc_next;
          r_c   <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          // r_c on the last bit is the carry into the MSB, so overflow is
          // taken directly here instead of being held in a separate flag.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_carry <= w_cout;
            r_ovf   <= r_c ^ w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=2 instances).
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp8_t;

  typedef struct packed {
    logic [1:0] s;
    logic       c;
    logic       o;
  } exp2_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, carry8, ovf8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, sub2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, carry2, ovf2;
  logic [1:0] sum2;

  int total = 0;
  int bad   = 0;

  exp8_t q8[$];
  exp2_t q2[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .overflow(ovf8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(ovf2)
  );

  function automatic exp8_t ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bb;
    logic [8:0] f;
    exp8_t      e;
    bb  = s ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb} + {8'b0, s};
    e.s = f[7:0];
    e.c = f[8];
    e.o = (a[7] == bb[7]) && (f[7] != a[7]);
    return e;
  endfunction

  function automatic exp2_t ref2(input logic [1:0] a, input logic [1:0] b, input logic s);
    logic [1:0] bb;
    logic [2:0] f;
    exp2_t      e;
    bb  = s ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb} + {2'b0, s};
    e.s = f[1:0];
    e.c = f[2];
    e.o = (a[1] == bb[1]) && (f[1] != a[1]);
    return e;
  endfunction

  // Caller drives start8 at a negedge in IDLE; the first posedge here is the
  // acceptance edge. n counts posedges up to the one after which done is seen.
  task automatic wait_done8(input bit hold, output int n, output int nb,
                            output bit ok, output bit chg);
    logic [7:0] s0;
    logic       c0, o0;
    s0 = sum8; c0 = carry8; o0 = ovf8;
    n = 0; nb = 0; ok = 1'b0; chg = 1'b0;
    repeat (40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) begin
        if (hold) begin a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; end
        else start8 = 1'b0;
      end
      if (busy8) nb++;
      if (done8) begin ok = 1'b1; start8 = 1'b0; break; end
      if (sum8 !== s0 || carry8 !== c0 || ovf8 !== o0) chg = 1'b1;
    end
    start8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'h000) begin
      bad++; $display("FAIL reset8: got busy=%b done=%b sum=%h c=%b o=%b want all 0",
                      busy8, done8, sum8, carry8, ovf8);
    end
    total++;
    if ({busy2, done2, sum2, carry2, ovf2} !== 6'h00) begin
      bad++; $display("FAIL reset2: got busy=%b done=%b sum=%h c=%b o=%b want all 0",
                      busy2, done2, sum2, carry2, ovf2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n, nb; bit ok, chg; exp8_t e;
    a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(ref8(a8, b8, sub8));
    wait_done8(1'b0, n, nb, ok, chg);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_timeout: done not seen in %0d cycles", n); end
    total++;
    if (n !== 9) begin bad++; $display("FAIL basic_latency: got %0d want 9", n); end
    total++;
    if (nb !== 8) begin bad++; $display("FAIL basic_busy: got %0d want 8", nb); end
    total++;
    if (chg) begin bad++; $display("FAIL basic_partial: outputs changed before done, got 1 want 0"); end
    e = q8.pop_front();
    total++;
    if ({sum8, carry8, ovf8} !== {e.s, e.c, e.o}) begin
      bad++; $display("FAIL basic_result: got %h/%b/%b want %h/%b/%b", sum8, carry8, ovf8, e.s, e.c, e.o);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (done8 !== 1'b0) begin bad++; $display("FAIL basic_pulse: done got %b want 0", done8); end
  endtask

  task automatic test_arith;
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       ts[4];
    int n, nb; bit ok, chg; exp8_t e;
    ta = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    tb = '{8'h01, 8'h01, 8'h07, 8'h01};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; sub8 = ts[i]; start8 = 1'b1;
      q8.push_back(ref8(a8, b8, sub8));
      wait_done8(1'b0, n, nb, ok, chg);
      total++;
      if (!ok) begin bad++; $display("FAIL arith%0d_timeout: done not seen", i); end
      e = q8.pop_front();
      total++;
      if ({sum8, carry8, ovf8} !== {e.s, e.c, e.o}) begin
        bad++; $display("FAIL arith%0d: got %h/%b/%b want %h/%b/%b", i, sum8, carry8, ovf8, e.s, e.c, e.o);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_abort;
    int n, nb, nd; bit ok, chg; exp8_t e;
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy8 !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy8); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    total++;
    if ({busy8, done8, sum8, carry8, ovf8} !== 12'h000) begin
      bad++; $display("FAIL abort_outputs: got busy=%b done=%b sum=%h c=%b o=%b want all 0",
                      busy8, done8, sum8, carry8, ovf8);
    end
    nd = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done8) nd++;
    end
    total++;
    if (nd !== 0) begin bad++; $display("FAIL abort_nodone: got %0d pulses want 0", nd); end
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(ref8(a8, b8, sub8));
    wait_done8(1'b0, n, nb, ok, chg);
    e = q8.pop_front();
    total++;
    if (!ok || {sum8, carry8, ovf8} !== {e.s, e.c, e.o}) begin
      bad++; $display("FAIL abort_rerun: got ok=%b %h/%b/%b want ok=1 %h/%b/%b",
                      ok, sum8, carry8, ovf8, e.s, e.c, e.o);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_start_ignored;
    int n, nb, nd, nbusy; bit ok, chg; exp8_t e;
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    q8.push_back(ref8(a8, b8, sub8));
    wait_done8(1'b1, n, nb, ok, chg);
    total++;
    if (!ok || n !== 9) begin bad++; $display("FAIL ignored_latency: got ok=%b n=%0d want ok=1 n=9", ok, n); end
    total++;
    if (nb !== 8) begin bad++; $display("FAIL ignored_busy: got %0d want 8", nb); end
    e = q8.pop_front();
    total++;
    if ({sum8, carry8, ovf8} !== {e.s, e.c, e.o}) begin
      bad++; $display("FAIL ignored_result: got %h/%b/%b want %h/%b/%b", sum8, carry8, ovf8, e.s, e.c, e.o);
    end
    nd = 0; nbusy = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (done8) nd++;
      if (busy8) nbusy++;
    end
    total++;
    if (nd !== 0 || nbusy !== 0) begin
      bad++; $display("FAIL ignored_nosecond: got done=%0d busy=%0d want 0/0", nd, nbusy);
    end
    total++;
    if (sum8 !== e.s) begin bad++; $display("FAIL ignored_hold: got %h want %h", sum8, e.s); end
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    q8.push_back(ref8(a8, b8, sub8));
    wait_done8(1'b0, n, nb, ok, chg);
    e = q8.pop_front();
    total++;
    if (!ok || {sum8, carry8, ovf8} !== {e.s, e.c, e.o}) begin
      bad++; $display("FAIL ignored_second: got ok=%b %h/%b/%b want ok=1 %h/%b/%b",
                      ok, sum8, carry8, ovf8, e.s, e.c, e.o);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int dn; bit hv, ok;
    logic [1:0] hs; logic hc, ho;
    exp2_t e;
    dn = 0; hv = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = i[4:0];
      a2 = v[1:0]; b2 = v[3:2]; sub2 = v[4]; start2 = 1'b1;
      q2.push_back(ref2(a2, b2, sub2));
      ok = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); @(negedge clk);
        if (k == 0) start2 = 1'b0;
        if (done2) begin
          ok = 1'b1; dn++;
          e = q2.pop_front();
          total++;
          if ({sum2, carry2, ovf2} !== {e.s, e.c, e.o}) begin
            bad++; $display("FAIL w2_result%0d: got %h/%b/%b want %h/%b/%b",
                            i, sum2, carry2, ovf2, e.s, e.c, e.o);
          end
          hs = e.s; hc = e.c; ho = e.o; hv = 1'b1;
          break;
        end
        if (hv) begin
          total++;
          if ({sum2, carry2, ovf2} !== {hs, hc, ho}) begin
            bad++; $display("FAIL w2_stable%0d: got %h/%b/%b want %h/%b/%b",
                            i, sum2, carry2, ovf2, hs, hc, ho);
          end
        end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL w2_timeout%0d: done got 0 want 1", i); end
      @(posedge clk); @(negedge clk);
      total++;
      if (done2 !== 1'b0 || {sum2, carry2, ovf2} !== {hs, hc, ho}) begin
        bad++; $display("FAIL w2_after%0d: got done=%b %h/%b/%b want done=0 %h/%b/%b",
                        i, done2, sum2, carry2, ovf2, hs, hc, ho);
      end
    end
    total++;
    if (dn !== 32) begin bad++; $display("FAIL w2_count: got %0d want 32", dn); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
